// File: rtl/parallel_collision_searcher.sv
// Parallel SHA-1 collision searcher: LANES hash lanes try consecutive
// counters in lock-step batches until one digest has enough leading zeros,
// the batch limit runs out, or the search is aborted.
//
// Handshake: a lane accepts one word per cycle while iValid=1 and oReady=1.
// oReady drops in the cycle after the 16th word and rises again when the
// digest is final. start is taken only in IDLE with every lane ready.

// Single-block SHA-1 compression (no padding); iInitial restarts from the IV.
module sha1 (
  input  logic         clk,
  input  logic         reset,
  input  logic         iValid,
  input  logic         iInitial,
  input  logic [31:0]  iData,
  output logic         oReady,
  output logic [159:0] oDigest
);
  logic [31:0] h_q [5];
  logic [31:0] h_d [5];
  logic [31:0] v_q [5];
  logic [31:0] v_d [5];
  logic [31:0] w_q [16];
  logic [31:0] w_d [16];
  logic [3:0]  cnt_q, cnt_d, cnt_base;
  logic [6:0]  rnd_q, rnd_d;
  logic        busy_q, busy_d;
  logic [31:0] f, kc, tmp, wx;

  // Word intake while idle, one round per cycle while busy.
  always_comb begin
    h_d = h_q; v_d = v_q; w_d = w_q;
    cnt_d = cnt_q; rnd_d = rnd_q; busy_d = busy_q;
    f = '0; kc = '0; tmp = '0; wx = '0;
    cnt_base = iInitial ? 4'd0 : cnt_q;
    if (busy_q) begin
      if (rnd_q < 7'd20) begin
        f = (v_q[1] & v_q[2]) | (~v_q[1] & v_q[3]); kc = 32'h5A827999;
      end else if (rnd_q < 7'd40) begin
        f = v_q[1] ^ v_q[2] ^ v_q[3]; kc = 32'h6ED9EBA1;
      end else if (rnd_q < 7'd60) begin
        f = (v_q[1] & v_q[2]) | (v_q[1] & v_q[3]) | (v_q[2] & v_q[3]); kc = 32'h8F1BBCDC;
      end else begin
        f = v_q[1] ^ v_q[2] ^ v_q[3]; kc = 32'hCA62C1D6;
      end
      tmp = {v_q[0][26:0], v_q[0][31:27]} + f + v_q[4] + kc + w_q[0];
      v_d[0] = tmp;
      v_d[1] = v_q[0];
      v_d[2] = {v_q[1][1:0], v_q[1][31:2]};
      v_d[3] = v_q[2];
      v_d[4] = v_q[3];
      // Rolling 16-word schedule window: w_q[0] is always W[t].
      for (int j = 0; j < 15; j++) w_d[j] = w_q[j+1];
      wx = w_q[13] ^ w_q[8] ^ w_q[2] ^ w_q[0];
      w_d[15] = {wx[30:0], wx[31]};
      rnd_d = rnd_q + 7'd1;
      if (rnd_q == 7'd79) begin
        for (int j = 0; j < 5; j++) h_d[j] = h_q[j] + v_d[j];
        busy_d = 1'b0;
      end
    end else if (iValid) begin
      if (iInitial) h_d = '{32'h67452301, 32'hEFCDAB89, 32'h98BADCFE, 32'h10325476, 32'hC3D2E1F0};
      for (int j = 0; j < 15; j++) w_d[j] = w_q[j+1];
      w_d[15] = iData;
      cnt_d = cnt_base + 4'd1;
      if (cnt_base == 4'd15) begin
        busy_d = 1'b1;
        rnd_d  = '0;
        v_d    = h_d;
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int j = 0; j < 5; j++) begin h_q[j] <= '0; v_q[j] <= '0; end
      for (int j = 0; j < 16; j++) w_q[j] <= '0;
      cnt_q <= '0; rnd_q <= '0; busy_q <= 1'b0;
    end else begin
      h_q <= h_d; v_q <= v_d; w_q <= w_d;
      cnt_q <= cnt_d; rnd_q <= rnd_d; busy_q <= busy_d;
    end
  end

  assign oReady  = ~busy_q;
  assign oDigest = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4]};
endmodule

// Registered test: digest has at least iTarget leading zero bits.
module CollisionChecker (
  input  logic         clk,
  input  logic         reset,
  input  logic [159:0] iDigest,
  input  logic [4:0]   iTarget,
  output logic         oCollision
);
  logic [7:0] lz;
  logic       hit_d, hit_q;

  // Leading-zero count: the highest set bit wins.
  always_comb begin
    lz = 8'd160;
    for (int b = 0; b < 160; b++) if (iDigest[b]) lz = 8'(159 - b);
    hit_d = (lz >= {3'b000, iTarget});
  end

  // One-cycle registered result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_q <= 1'b0;
    else       hit_q <= hit_d;
  end

  assign oCollision = hit_q;
endmodule

module parallel_collision_searcher #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [4:0]   target,
  input  logic [511:0] message,
  input  logic [31:0]  counter,
  input  logic [31:0]  increment,
  input  logic [31:0]  max_batches,
  output logic         busy,
  output logic         done,
  output logic         found,
  output logic         exhausted,
  output logic         aborted,
  output logic [31:0]  result,
  output logic [2:0]   result_lane,
  output logic [31:0]  digests_computed,
  output logic [2:0]   dbg_state
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WAIT, S_CHECK, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [3:0]         k_q, k_d;
  logic               chk_q, chk_d;
  logic [LANES-1:0]   seen_q, seen_d;
  logic [31:0]        cnt_q [LANES];
  logic [31:0]        cnt_d [LANES];
  logic [31:0]        batch_q, batch_d, inc_q, inc_d, max_q, max_d;
  logic [4:0]         tgt_q, tgt_d;
  logic [511:0]       msg_q, msg_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               found_q, found_d, exh_q, exh_d, abt_q, abt_d;
  logic [31:0]        result_q, result_d, digests_q, digests_d;
  logic [2:0]         rlane_q, rlane_d;

  logic [LANES-1:0]       ready, coll_raw, coll_vec;
  logic [LANES-1:0][31:0] lane_word;
  logic [159:0]           digest [LANES];
  logic [31:0]            msg_word, stride, coll_cnt;
  logic [2:0]             coll_idx;
  logic                   load_v, load_init, go_abort;

  assign load_v    = (state_q == S_LOAD);
  assign load_init = load_v && (k_q == 4'd0);
  assign msg_word  = msg_q[9'd511 - {k_q, 5'b00000} -: 32];
  assign stride    = 32'(LANES) * inc_q;
  assign coll_vec  = coll_raw;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign lane_word[i] = (k_q == 4'd0) ? cnt_q[i] : msg_word;
    sha1 u_sha1 (
      .clk(clk), .reset(reset), .iValid(load_v), .iInitial(load_init),
      .iData(lane_word[i]), .oReady(ready[i]), .oDigest(digest[i])
    );
    CollisionChecker u_chk (
      .clk(clk), .reset(reset), .iDigest(digest[i]), .iTarget(tgt_q),
      .oCollision(coll_raw[i])
    );
  end

  // Lowest-index colliding lane and its counter.
  always_comb begin
    coll_idx = '0;
    coll_cnt = cnt_q[0];
    for (int i = LANES - 1; i >= 0; i--) begin
      if (coll_vec[i]) begin
        coll_idx = 3'(i);
        coll_cnt = cnt_q[i];
      end
    end
  end

  // Search sequencing and result capture.
  always_comb begin
    state_d = state_q; k_d = k_q; chk_d = chk_q; seen_d = seen_q;
    cnt_d = cnt_q; batch_d = batch_q; inc_d = inc_q; max_d = max_q;
    tgt_d = tgt_q; msg_d = msg_q;
    found_d = found_q; exh_d = exh_q; abt_d = abt_q;
    result_d = result_q; rlane_d = rlane_q; digests_d = digests_q;
    go_abort = 1'b0;
    case (state_q)
      S_IDLE: if (start && (&ready)) begin
        state_d = S_LOAD;
        tgt_d = target; msg_d = message; inc_d = increment; max_d = max_batches;
        for (int i = 0; i < LANES; i++) cnt_d[i] = counter + 32'(i) * increment;
        batch_d = '0; k_d = '0; seen_d = '0;
        found_d = 1'b0; exh_d = 1'b0; abt_d = 1'b0;
        result_d = '0; rlane_d = '0; digests_d = '0;
      end
      S_LOAD: if (abort) go_abort = 1'b1;
        else begin
          k_d = k_q + 4'd1;
          if (k_q == 4'd15) state_d = S_WAIT;
        end
      S_WAIT: if (abort) go_abort = 1'b1;
        else begin
          seen_d = seen_q | ~ready;
          if (&(seen_q & ready)) begin
            state_d = S_CHECK; chk_d = 1'b0;
            digests_d = digests_q + 32'(LANES);
            batch_d = batch_q + 32'd1;
          end
        end
      S_CHECK: if (!chk_q) begin
          // First cycle only lets the checkers register the fresh digests.
          if (abort) go_abort = 1'b1;
          else chk_d = 1'b1;
        end else if (|coll_vec) begin
          found_d = 1'b1; result_d = coll_cnt; rlane_d = coll_idx; state_d = S_DONE;
        end else if (abort) begin
          go_abort = 1'b1;
        end else begin
          for (int i = 0; i < LANES; i++) cnt_d[i] = cnt_q[i] + stride;
          if ((max_q != 32'd0) && (batch_q == max_q)) begin
            exh_d = 1'b1; result_d = cnt_q[0] + stride; rlane_d = '0; state_d = S_DONE;
          end else begin
            state_d = S_LOAD; k_d = '0; seen_d = '0;
          end
        end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (go_abort) begin
      state_d = S_DONE; abt_d = 1'b1; result_d = cnt_q[0]; rlane_d = '0;
    end
    busy_d = (state_d == S_LOAD) || (state_d == S_WAIT) || (state_d == S_CHECK);
    done_d = (state_d == S_DONE);
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE; k_q <= '0; chk_q <= 1'b0; seen_q <= '0;
      for (int i = 0; i < LANES; i++) cnt_q[i] <= '0;
      batch_q <= '0; inc_q <= '0; max_q <= '0; tgt_q <= '0; msg_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0;
      found_q <= 1'b0; exh_q <= 1'b0; abt_q <= 1'b0;
      result_q <= '0; rlane_q <= '0; digests_q <= '0;
    end else begin
      state_q <= state_d; k_q <= k_d; chk_q <= chk_d; seen_q <= seen_d;
      cnt_q <= cnt_d;
      batch_q <= batch_d; inc_q <= inc_d; max_q <= max_d; tgt_q <= tgt_d; msg_q <= msg_d;
      busy_q <= busy_d; done_q <= done_d;
      found_q <= found_d; exh_q <= exh_d; abt_q <= abt_d;
      result_q <= result_d; rlane_q <= rlane_d; digests_q <= digests_d;
    end
  end

  assign busy             = busy_q;
  assign done             = done_q;
  assign found            = found_q;
  assign exhausted        = exh_q;
  assign aborted          = abt_q;
  assign result           = result_q;
  assign result_lane      = rlane_q;
  assign digests_computed = digests_q;
  assign dbg_state        = state_q;
endmodule

// File: doc/parallel_collision_searcher.md
PARALLEL_COLLISION_SEARCHER -- requirements
Module: parallel_collision_searcher

Interface
REQ-001 Parameter LANES, default 4, number of parallel SHA-1 lanes; SHALL be legal for 1..8.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request to begin a search; honoured only per REQ-011.
REQ-005 abort  input  1  request to terminate an in-progress search.
REQ-006 target  input  5  zero count that identifies a collision.
REQ-007 message  input  512  base message block.
REQ-008 counter / increment / max_batches  input  32 each  base counter, per-digest stride, batch limit (0 = unlimited).
REQ-009 busy  output  1 ; done  output  1 ; found / exhausted / aborted  output  1 each ; result  output  32 ; result_lane  output  3 ; digests_computed  output  32.

Function
REQ-010 Lanes SHALL be built from one sha1 and one CollisionChecker instance per lane, sharing clk and reset.
REQ-011 States SHALL be IDLE, LOAD, WAIT, CHECK, DONE; IDLE->LOAD only when start=1 and every lane's oReady=1.
REQ-012 On IDLE->LOAD, target, message, increment and max_batches SHALL be latched; lane i counter SHALL be set to counter + i*increment, mod 2^32; batch count SHALL be set to 0.
REQ-013 LOAD SHALL last exactly 16 cycles, word index k=0..15, broadcast to all lanes simultaneously.
REQ-014 In LOAD, iValid=1 each cycle and iInitial=1 only at k=0.
REQ-015 In LOAD, lane word 0 SHALL be the lane counter and word k>=1 SHALL be message[511-32k -: 32].
REQ-016 In WAIT, each lane SHALL keep a busy-seen flag, set when its oReady=0.
REQ-017 WAIT->CHECK when every lane has busy-seen set and oReady=1 in the same cycle; flags SHALL clear on entry to LOAD.
REQ-018 On WAIT->CHECK, digests_computed SHALL increase by LANES (wrapping mod 2^32) and batch count by 1.
REQ-019 CHECK SHALL last 2 cycles; the per-lane collision vector SHALL be sampled on the second cycle, to cover the checker's 1-cycle registered latency.
REQ-020 If any lane collides, the lowest-index colliding lane SHALL win: found=1, result=that lane's counter, result_lane=its index, -> DONE.
REQ-021 If no lane collides, every lane counter SHALL add LANES*increment (mod 2^32).
REQ-022 After REQ-021, if max_batches!=0 and batch count==max_batches: exhausted=1, result=new lane-0 counter, result_lane=0, -> DONE; otherwise -> LOAD.
REQ-023 abort=1 in LOAD, WAIT or CHECK SHALL force the next state to DONE with aborted=1, result=lane-0 counter, result_lane=0.
REQ-024 If abort and a collision coincide in the CHECK sample cycle, found SHALL win and aborted SHALL stay 0.
REQ-025 abort in IDLE or DONE SHALL be ignored, and start outside IDLE SHALL be ignored.
REQ-026 DONE SHALL last 1 cycle with done=1, then -> IDLE.
REQ-027 busy SHALL be 1 in LOAD, WAIT and CHECK only.
REQ-028 found, exhausted, aborted, result, result_lane and digests_computed SHALL hold after DONE until the next accepted start, which SHALL clear all of them to 0.
REQ-029 Exactly one of found, exhausted, aborted SHALL be 1 after any DONE.

Reset
REQ-030 reset=1 SHALL immediately force state IDLE and clear busy, done, flags, result, result_lane, digests_computed, lane counters and batch count to 0, including mid-search.
REQ-031 After reset deasserts, start SHALL be accepted only once all lanes report oReady=1.

Verification
REQ-032 LANES=4, target=0, counter=0x100, increment=1, start: found=1, result=0x100, result_lane=0, digests_computed=4, done pulses once.
REQ-033 LANES=4, target=31, counter=0, increment=2, max_batches=3: exhausted=1, digests_computed=12, result=0x18.
REQ-034 LANES=4, counter=0xFFFFFFFF, increment=1: lane counters loaded as 0xFFFFFFFF, 0, 1, 2 (word 0 checked per lane).
REQ-035 Abort asserted in the 5th LOAD cycle: aborted=1, done next cycle, digests_computed=0; a new start is accepted only after all oReady=1.
REQ-036 Force collisions on lanes 1 and 3 in the same batch with abort asserted in the CHECK sample cycle: found=1, aborted=0, result_lane=1.
REQ-037 reset asserted during WAIT: all outputs 0 and busy=0 in the same cycle; a subsequent search completes normally.
